// File: rtl/wdg_rst_gen_if.sv
// Reset-generator request/status bundle: request inputs plus system reset,
// cause and count outputs.
interface wdg_rst_gen_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 wdg_rst_i;
   logic                 ext_rst_i;
   logic                 sw_rst_i;
   logic                 cause_clr_i;
   logic                 sys_rst_o;
   logic                 sys_rst_n_o;
   logic                 busy_o;
   logic [2:0]           cause_o;
   logic                 por_flag_o;
   logic [CNT_WIDTH-1:0] rst_cnt_o;

   modport master (
      output wdg_rst_i, ext_rst_i, sw_rst_i, cause_clr_i,
      input  sys_rst_o, sys_rst_n_o, busy_o, cause_o, por_flag_o, rst_cnt_o
   );

   modport slave (
      input  wdg_rst_i, ext_rst_i, sw_rst_i, cause_clr_i,
      output sys_rst_o, sys_rst_n_o, busy_o, cause_o, por_flag_o, rst_cnt_o
   );
endinterface

// File: rtl/wdg_rst_gen.sv
// Merges watchdog, external and software reset requests into a stretched
// system reset with a cool-down window, sticky cause flags and a reset count.
module wdg_rst_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYC    = 16,
   parameter int COOL_CYC    = 8,
   parameter int CNT_WIDTH   = 8
) (
   input  logic         rtc_clk_i,
   input  logic         rst_i,
   wdg_rst_gen_if.slave bus
);
   localparam int HOLD_W = $clog2((HOLD_CYC < 2) ? 2 : HOLD_CYC);
   localparam int COOL_W = $clog2((COOL_CYC < 2) ? 2 : COOL_CYC);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);
   localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOL_CYC - 1);

   typedef enum logic [1:0] {IDLE, ASSERT, COOL} state_t;

   state_t                 state, nxt;
   logic [SYNC_STAGES-1:0] ext_sync;
   logic                   ext_s, req;
   logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
   logic [COOL_W-1:0]      cool_cnt, cool_nxt;
   logic                   pending, pend_nxt, cnt_inc;
   logic [CNT_WIDTH-1:0]   rst_cnt;
   logic [2:0]             cause;
   logic                   por_flag, sys_rst, sys_rst_n, busy;

   assign ext_s = ext_sync[SYNC_STAGES-1];
   assign req   = bus.wdg_rst_i | ext_s | bus.sw_rst_i;

   always_ff @(posedge rtc_clk_i or posedge rst_i) begin
      if (rst_i) ext_sync <= '0;
      else       ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_rst_i};
   end

   always_comb begin
      nxt      = state;
      hold_nxt = hold_cnt;
      cool_nxt = cool_cnt;
      pend_nxt = pending;
      cnt_inc  = 1'b0;
      unique case (state)
         IDLE: if (req) begin
            nxt      = ASSERT;
            hold_nxt = '0;
            cnt_inc  = 1'b1;
         end
         ASSERT: begin
            // Once the minimum width is met, a live request keeps stretching it.
            if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + 1'b1;
            else if (!req) begin
               nxt      = COOL;
               cool_nxt = '0;
            end
         end
         COOL: begin
            cool_nxt = cool_cnt + 1'b1;
            pend_nxt = pending | req;
            if (cool_cnt == COOL_MAX) begin
               pend_nxt = 1'b0;
               if (pending | req) begin
                  nxt      = ASSERT;
                  hold_nxt = '0;
                  cnt_inc  = 1'b1;
               end else begin
                  nxt = IDLE;
               end
            end
         end
         default: nxt = ASSERT;
      endcase
   end

   always_ff @(posedge rtc_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ASSERT;
         hold_cnt  <= '0;
         cool_cnt  <= '0;
         pending   <= 1'b0;
         rst_cnt   <= '0;
         cause     <= '0;
         por_flag  <= 1'b1;
         sys_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         busy      <= 1'b1;
      end else begin
         state    <= nxt;
         hold_cnt <= hold_nxt;
         cool_cnt <= cool_nxt;
         pending  <= pend_nxt;
         if (cnt_inc && (rst_cnt != '1)) rst_cnt <= rst_cnt + 1'b1;
         // A source seen in the same cycle as a clear survives it.
         cause    <= (bus.cause_clr_i ? 3'b000 : cause) | {bus.sw_rst_i, ext_s, bus.wdg_rst_i};
         if (bus.cause_clr_i) por_flag <= 1'b0;
         sys_rst   <= (nxt == ASSERT);
         sys_rst_n <= (nxt != ASSERT);
         busy      <= (nxt != IDLE);
      end
   end

   assign bus.sys_rst_o   = sys_rst;
   assign bus.sys_rst_n_o = sys_rst_n;
   assign bus.busy_o      = busy;
   assign bus.cause_o     = cause;
   assign bus.por_flag_o  = por_flag;
   assign bus.rst_cnt_o   = rst_cnt;
endmodule
